// File: rtl/pipe_reg_elastic.sv
// Elastic inter-stage register with a main/skid pair; accepted entries appear one cycle later.
// in_ready comes from the skid state only; back-pressured cycles feed a saturating stall counter.
module pipe_reg_elastic #(
  parameter int DATA_W = 32,
  parameter int DST_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic [DST_W-1:0]  out_dst,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              regwrite;
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  entry_t in_entry;
  logic   accept;
  logic   drain;

  assign in_entry = '{regwrite: in_regwrite, dst: in_dst, data: in_data};
  assign accept   = in_valid & ~skid_valid_q;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      // Payloads keep stale data; out_regwrite is gated by valid so they are harmless.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      main_valid_d = accept;
      if (accept) begin
        main_d = in_entry;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign in_ready     = ~skid_valid_q;
  assign out_valid    = main_valid_q;
  assign out_regwrite = main_q.regwrite & main_valid_q;
  assign out_dst      = main_q.dst;
  assign out_data     = main_q.data;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic with a 4-bit stall counter so saturation is reachable.
module tb_pipe_reg_elastic;

  localparam int DATA_W = 32;
  localparam int DST_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic [DST_W-1:0]  in_dst;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_regwrite;
  logic [DST_W-1:0]  out_dst;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_reg_elastic #(.DATA_W(DATA_W), .DST_W(DST_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_regwrite  (in_regwrite),
    .in_dst       (in_dst),
    .in_data      (in_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_regwrite (out_regwrite),
    .out_dst      (out_dst),
    .out_data     (out_data),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic rw, input logic [3:0] d, input logic [31:0] x);
    in_valid    = v;
    in_regwrite = rw;
    in_dst      = d;
    in_data     = x;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    offer(1'b0, 1'b0, 4'd0, 32'd0);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_stall",     {28'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Streaming with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 1'b1, 4'(i), 32'(i));
      tick();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data",  out_data,           32'(i));
      chk("stream_dst",   {28'd0, out_dst},   32'(i));
      chk("stream_ready", {31'd0, in_ready},  32'd1);
    end
    offer(1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    chk("stream_end_valid", {31'd0, out_valid}, 32'd0);
    chk("stream_stall",     {28'd0, stall_cnt}, 32'd0);

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 4'd10, 32'hAAAA_AAAA);
    tick();
    chk("bp_a_data",  out_data,          32'hAAAA_AAAA);
    chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
    offer(1'b1, 1'b1, 4'd11, 32'hBBBB_BBBB);
    tick();
    chk("bp_b_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_b_data",  out_data,          32'hAAAA_AAAA);
    offer(1'b1, 1'b1, 4'd12, 32'hCCCC_CCCC);
    tick();
    chk("bp_c_ready", {31'd0, in_ready},  32'd0);
    chk("bp_c_data",  out_data,           32'hAAAA_AAAA);
    chk("bp_stall",   {28'd0, stall_cnt}, 32'd2);
    out_ready = 1'b1;
    tick();
    chk("drain_b_data",  out_data,          32'hBBBB_BBBB);
    chk("drain_b_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("drain_c_data",  out_data,           32'hCCCC_CCCC);
    chk("drain_c_dst",   {28'd0, out_dst},   32'd12);
    offer(1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    chk("drain_empty",   {31'd0, out_valid}, 32'd0);
    chk("drain_stall",   {28'd0, stall_cnt}, 32'd2);

    // Flush kills main, skid and the entry offered alongside it
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 4'd3, 32'h0000_1234);
    tick();
    offer(1'b1, 1'b1, 4'd5, 32'h0000_5678);
    tick();
    chk("fl_pre_ready", {31'd0, in_ready}, 32'd0);
    offer(1'b1, 1'b1, 4'd7, 32'h0000_9ABC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 1'b0, 4'd0, 32'd0);
    chk("fl_valid",    {31'd0, out_valid},    32'd0);
    chk("fl_regwrite", {31'd0, out_regwrite}, 32'd0);
    chk("fl_ready",    {31'd0, in_ready},     32'd1);
    chk("fl_stall",    {28'd0, stall_cnt},    32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Bubble must never carry RegWrite
    offer(1'b0, 1'b1, 4'd9, 32'hDEAD_BEEF);
    tick();
    chk("bubble_regwrite", {31'd0, out_regwrite}, 32'd0);
    chk("bubble_valid",    {31'd0, out_valid},    32'd0);

    // Stall counter saturation (starts at 4)
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 4'd2, 32'h0000_D00D);
    tick();
    offer(1'b0, 1'b0, 4'd0, 32'd0);
    chk("sat_start", {28'd0, stall_cnt}, 32'd4);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid", {28'd0, stall_cnt}, 32'd14);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_top", {28'd0, stall_cnt}, 32'd15);
    chk("sat_regwrite", {31'd0, out_regwrite}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_after_flush", {28'd0, stall_cnt}, 32'd15);

    // Asynchronous reset with main and skid both full
    offer(1'b1, 1'b1, 4'd4, 32'h0000_0E0E);
    tick();
    offer(1'b1, 1'b1, 4'd6, 32'h0000_0F0F);
    tick();
    offer(1'b0, 1'b0, 4'd0, 32'd0);
    chk("ar_pre_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",    {31'd0, out_valid},    32'd0);
    chk("ar_regwrite", {31'd0, out_regwrite}, 32'd0);
    chk("ar_ready",    {31'd0, in_ready},     32'd1);
    chk("ar_stall",    {28'd0, stall_cnt},    32'd0);
    chk("ar_data",     out_data,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    offer(1'b1, 1'b0, 4'd8, 32'h0000_7777);
    tick();
    offer(1'b0, 1'b0, 4'd0, 32'd0);
    chk("ar_first_valid",    {31'd0, out_valid},    32'd1);
    chk("ar_first_data",     out_data,              32'h0000_7777);
    chk("ar_first_regwrite", {31'd0, out_regwrite}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
